// File: rtl/xor_frame_checker.sv
// xor_frame_checker: folds each frame of words into an XOR signature, parity, length and overflow flag,
// and presents the result on a valid/ready port.
module xor_frame_checker #(
  parameter int WIDTH = 8,
  parameter int MAXLEN = 16,
  parameter int ODD = 0,
  localparam int LW = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sig,
  output logic             par,
  output logic [LW-1:0]    len,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, sig_q, sig_d, acc_nx;
  logic [LW-1:0] cnt_q, cnt_d, len_q, len_d, cnt_nx;
  logic par_q, par_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic take, give, term;
  assign in_ready = !reset && state_q != HOLD;
  assign take = in_valid && in_ready;
  assign give = out_valid_q && out_ready;
  assign acc_nx = (state_q == IDLE) ? in_data : acc_q ^ in_data;
  assign cnt_nx = (state_q == IDLE) ? LW'(1) : cnt_q + LW'(1);
  // a frame ends on an explicit last word or when the length cap is reached
  assign term = take && (in_last || cnt_nx == LW'(MAXLEN));
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sig_d = sig_q;
    len_d = len_q;
    par_d = par_q;
    ovf_d = ovf_q;
    out_valid_d = out_valid_q;
    if (state_q == HOLD) begin
      if (give) begin
        out_valid_d = 1'b0;
        acc_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end
    end else begin
      if (take) begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        state_d = ACC;
      end
      if (term) begin
        sig_d = acc_nx;
        len_d = cnt_nx;
        par_d = (ODD != 0) ? ~^acc_nx : ^acc_nx;
        ovf_d = !in_last;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      sig_q <= '0;
      len_q <= '0;
      par_q <= 1'b0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sig_q <= sig_d;
      len_q <= len_d;
      par_q <= par_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  assign sig = sig_q;
  assign par = par_q;
  assign len = len_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_xor_frame_checker.sv
// tb_xor_frame_checker: random and directed frames into even- and odd-parity instances, checked
// against a queue-based frame model.
module tb_xor_frame_checker;
  localparam int W = 8;
  localparam int ML = 4;
  localparam int LW = $clog2(ML + 1);
  typedef struct {
    logic [W-1:0] sig;
    int len;
    bit ovf;
  } res_t;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic rdy_e, ov_e, par_e, ovf_e, rdy_o, ov_o, par_o, ovf_o;
  logic [W-1:0] sig_e, sig_o;
  logic [LW-1:0] len_e, len_o;
  int n_chk = 0, n_fail = 0;
  bit done = 0;
  logic [W-1:0] frame[$];
  res_t exp_q[$];
  xor_frame_checker #(.WIDTH(W), .MAXLEN(ML), .ODD(0)) u_even (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_e), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_e), .out_ready(out_ready), .sig(sig_e), .par(par_e),
    .len(len_e), .ovf(ovf_e));
  xor_frame_checker #(.WIDTH(W), .MAXLEN(ML), .ODD(1)) u_odd (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_o), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_o), .out_ready(out_ready), .sig(sig_o), .par(par_o),
    .len(len_o), .ovf(ovf_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit parity(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += v[i];
    return bit'(ones % 2);
  endfunction
  // reference: a frame is the list of accepted words; result is their XOR, count and cap flag
  always @(negedge clk) begin
    if (reset) begin
      chk("rdy_in_reset_e", rdy_e, 0);
      chk("rdy_in_reset_o", rdy_o, 0);
      frame.delete();
      exp_q.delete();
    end else begin
      chk("in_ready_e", rdy_e, exp_q.size() == 0);
      chk("in_ready_o", rdy_o, exp_q.size() == 0);
      chk("out_valid_e", ov_e, exp_q.size() != 0);
      chk("out_valid_o", ov_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("sig_e", sig_e, exp_q[0].sig);
        chk("sig_o", sig_o, exp_q[0].sig);
        chk("par_e", par_e, parity(exp_q[0].sig));
        chk("par_o", par_o, !parity(exp_q[0].sig));
        chk("len_e", len_e, exp_q[0].len);
        chk("len_o", len_o, exp_q[0].len);
        chk("ovf_e", ovf_e, exp_q[0].ovf);
        chk("ovf_o", ovf_o, exp_q[0].ovf);
        if (out_ready) void'(exp_q.pop_front());
      end else if (in_valid) begin
        frame.push_back(in_data);
        if (in_last || frame.size() == ML) begin
          res_t r;
          r.sig = '0;
          foreach (frame[i]) r.sig ^= frame[i];
          r.len = frame.size();
          r.ovf = !in_last;
          exp_q.push_back(r);
          frame.delete();
        end
      end
    end
  end
  task automatic send(input logic [W-1:0] d, input logic l);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    forever begin
      @(negedge clk);
      if (rdy_e) break;
      if (++n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_data = W'($urandom);
    in_last = 1'($urandom);
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(2);
    reset = 0;
    @(negedge clk);
    chk("rst_valid", ov_e, 0);
    chk("rst_sig", sig_e, 0);
    chk("rst_par", par_e, 0);
    chk("rst_len", len_e, 0);
    chk("rst_ovf", ovf_e, 0);
    chk("rst_rdy", rdy_e, 1);
    tick(1);
    out_ready = 1;
    send(8'hA5, 1);
    @(negedge clk);
    chk("single_sig", sig_e, 8'hA5);
    chk("single_len", len_e, 1);
    tick(1);
    @(negedge clk);
    chk("single_done", ov_e, 0);
    chk("single_rdy", rdy_e, 1);
    tick(1);
    send(8'h0F, 0);
    send(8'hF0, 0);
    send(8'h01, 1);
    @(negedge clk);
    chk("multi_sig", sig_e, 8'hFE);
    chk("multi_par", par_e, 1);
    chk("multi_len", len_e, 3);
    tick(2);
    out_ready = 0;
    send(8'h5A, 1);
    in_valid = 1;
    in_data = 8'hFF;
    in_last = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rdy", rdy_e, 0);
      chk("bp_sig", sig_e, 8'h5A);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send(8'hFF, 1);
    @(negedge clk);
    chk("bp_new_sig", sig_e, 8'hFF);
    tick(2);
    out_ready = 0;
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h04, 0);
    send(8'h08, 0);
    @(negedge clk);
    chk("ovf_sig", sig_e, 8'h0F);
    chk("ovf_len", len_e, 4);
    chk("ovf_flag", ovf_e, 1);
    @(posedge clk);
    #1;
    out_ready = 1;
    send(8'h10, 1);
    @(negedge clk);
    chk("post_ovf_sig", sig_e, 8'h10);
    chk("post_ovf_len", len_e, 1);
    chk("post_ovf_flag", ovf_e, 0);
    tick(2);
    send(8'h33, 0);
    send(8'h44, 0);
    reset = 1;
    tick(1);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", ov_o, 0);
    end
    tick(1);
    send(8'h00, 1);
    @(negedge clk);
    chk("odd_sig", sig_o, 0);
    chk("odd_par", par_o, 1);
    chk("odd_len", len_o, 1);
    tick(2);
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          int n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) begin
            tick($urandom_range(0, 2));
            send(W'($urandom), k == n - 1);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    out_ready = 1;
    tick(4);
    chk("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
